hazard_fwd_unit: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline. It computes forwarding selects for NUM_SRC EX-stage operands from MEM and WB, with priority MEM > WB and x0 never forwarded. It also detects load-use hazards, generates branch flushes, and tracks one in-flight multi-cycle (MUL/DIV) operation with an internal latency counter and a saturating stall counter. It sits beside the ID/EX pipeline registers and drives their stall, bubble and flush controls.

---
 rtl/hazard_fwd_unit_pkg.sv | 8 +
 rtl/hazard_fwd_unit_lane.sv | 18 +
 rtl/hazard_fwd_unit.sv | 95 +++++++++
 tb/tb_hazard_fwd_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// hazard_pkg: shared forwarding-select codes, register-zero index and multi-cycle FSM states.
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;
  localparam int REG_ZERO = 0;
  typedef enum logic {IDLE, BUSY} mc_state_e;
endpackage

// File: rtl/hazard_fwd_unit_lane.sv
// fwd_sel_lane: forwarding select for one EX operand, MEM over WB, x0 never forwarded.
module fwd_sel_lane
  import hazard_pkg::*;
#(
  parameter int RBITS = 5
) (
  input  logic [RBITS-1:0] rs,
  input  logic [RBITS-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [RBITS-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic [1:0]       sel
);
  always_comb
    sel = (rs == RBITS'(REG_ZERO)) ? FWD_RF :
          (mem_reg_write & (rs == mem_rd)) ? FWD_MEM :
          (wb_reg_write & (rs == wb_rd)) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: forwarding selects, load-use / multi-cycle stalls, branch flush and a stall counter.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int RBITS = 5,
  parameter int NUM_SRC = 2,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*RBITS-1:0] id_rs,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic [RBITS-1:0]         id_rd,
  input  logic                     id_reg_write,
  input  logic                     id_is_mc,
  input  logic                     ex_valid,
  input  logic [NUM_SRC*RBITS-1:0] ex_rs,
  input  logic [RBITS-1:0]         ex_rd,
  input  logic                     ex_mem_read,
  input  logic                     ex_is_mc,
  input  logic                     branch_taken_ex,
  input  logic [RBITS-1:0]         mem_rd,
  input  logic                     mem_reg_write,
  input  logic [RBITS-1:0]         wb_rd,
  input  logic                     wb_reg_write,
  input  logic                     stat_clr,
  output logic [2*NUM_SRC-1:0]     fwd_sel,
  output logic                     stall_if,
  output logic                     stall_id,
  output logic                     bubble_ex,
  output logic                     flush_if,
  output logic                     flush_id,
  output logic                     mc_busy,
  output logic [RBITS-1:0]         mc_rd,
  output logic                     mc_done,
  output logic [CNT_W-1:0]         stall_count
);
  localparam int LW = 4;
  localparam logic [RBITS-1:0] RZ = RBITS'(REG_ZERO);
  mc_state_e state, state_nx;
  logic [LW-1:0] cnt;
  logic lu, mh, hz, cap;
  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_lane
      fwd_sel_lane #(.RBITS(RBITS)) u_lane (
        .rs(ex_rs[g*RBITS +: RBITS]),
        .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write),
        .sel(fwd_sel[2*g +: 2])
      );
    end
  endgenerate
  always_comb begin
    lu = 1'b0;
    mh = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      lu = lu | (id_rs_used[k] & (id_rs[k*RBITS +: RBITS] == ex_rd));
      mh = mh | (id_rs_used[k] & (id_rs[k*RBITS +: RBITS] == mc_rd));
    end
    lu = lu & ex_valid & ex_mem_read & (ex_rd != RZ);
    mh = mc_busy & (((mh | (id_reg_write & (id_rd == mc_rd))) & (mc_rd != RZ)) | id_is_mc);
    hz = (lu | mh) & ~branch_taken_ex;
  end
  assign stall_if = hz;
  assign stall_id = hz;
  assign bubble_ex = hz;
  assign flush_if = branch_taken_ex;
  assign flush_id = branch_taken_ex;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // a new op may enter on the final busy cycle so back-to-back ops keep mc_busy high
  always_comb begin
    cap = ex_valid & ex_is_mc & ((state == IDLE) | mc_done);
    state_nx = cap ? BUSY : mc_done ? IDLE : state;
  end
  always_comb begin
    mc_busy = (state == BUSY);
    mc_done = mc_busy & (cnt == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      mc_rd <= '0;
      stall_count <= '0;
    end else begin
      cnt <= cap ? LW'(MC_LATENCY - 1) : (mc_busy & (cnt != '0)) ? cnt - 1'b1 : cnt;
      mc_rd <= cap ? ex_rd : mc_rd;
      stall_count <= stat_clr ? '0 : (hz & ~&stall_count) ? stall_count + 1'b1 : stall_count;
    end
  end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed literal checks plus randomized run against a behavioural model.
module tb_hazard_fwd_unit;
  localparam int RB = 5;
  localparam int NS = 2;
  localparam int LAT = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst;
  logic [NS*RB-1:0] id_rs, ex_rs;
  logic [NS-1:0] id_rs_used;
  logic [RB-1:0] id_rd, ex_rd, mem_rd, wb_rd, mc_rd;
  logic id_reg_write, id_is_mc, ex_valid, ex_mem_read, ex_is_mc, branch_taken_ex;
  logic mem_reg_write, wb_reg_write, stat_clr;
  logic [2*NS-1:0] fwd_sel;
  logic stall_if, stall_id, bubble_ex, flush_if, flush_id, mc_busy, mc_done;
  logic [CW-1:0] stall_count;
  int checks = 0;
  int failures = 0;
  int m_rem, m_cnt;
  logic [RB-1:0] m_rd;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.RBITS(RB), .NUM_SRC(NS), .MC_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_mc(id_is_mc), .ex_valid(ex_valid), .ex_rs(ex_rs),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mc(ex_is_mc),
    .branch_taken_ex(branch_taken_ex), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .stat_clr(stat_clr), .fwd_sel(fwd_sel),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_if(flush_if),
    .flush_id(flush_id), .mc_busy(mc_busy), .mc_rd(mc_rd), .mc_done(mc_done),
    .stall_count(stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_sel(input logic [RB-1:0] s);
    if (s == 0) return 2'b00;
    if (s == mem_rd && mem_reg_write) return 2'b01;
    if (s == wb_rd && wb_reg_write) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic exp_hz();
    logic lu = 1'b0;
    logic mh = 1'b0;
    for (int k = 0; k < NS; k++) begin
      logic [RB-1:0] s;
      s = id_rs[k*RB +: RB];
      if (id_rs_used[k] && s == ex_rd) lu = 1'b1;
      if (id_rs_used[k] && s == m_rd && m_rd != 0) mh = 1'b1;
    end
    lu = lu && ex_valid && ex_mem_read && ex_rd != 0;
    if (id_reg_write && id_rd == m_rd && m_rd != 0) mh = 1'b1;
    if (id_is_mc) mh = 1'b1;
    mh = mh && (m_rem > 0);
    return (lu || mh) && !branch_taken_ex;
  endfunction

  task automatic model_check();
    logic [2*NS-1:0] ef;
    logic h;
    for (int k = 0; k < NS; k++) ef[2*k +: 2] = exp_sel(ex_rs[k*RB +: RB]);
    h = exp_hz();
    chk("m_fwd_sel", fwd_sel, ef);
    chk("m_stall_if", stall_if, h);
    chk("m_stall_id", stall_id, h);
    chk("m_bubble_ex", bubble_ex, h);
    chk("m_flush_if", flush_if, branch_taken_ex);
    chk("m_flush_id", flush_id, branch_taken_ex);
    chk("m_mc_busy", mc_busy, m_rem > 0);
    chk("m_mc_done", mc_done, m_rem == 1);
    chk("m_mc_rd", mc_rd, m_rd);
    chk("m_stall_count", stall_count, m_cnt);
  endtask

  task automatic model_update();
    logic h;
    h = exp_hz();
    if (rst) begin
      m_rem = 0;
      m_rd = '0;
      m_cnt = 0;
    end else begin
      m_cnt = stat_clr ? 0 : (h && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
      if (ex_valid && ex_is_mc && m_rem <= 1) begin
        m_rem = LAT;
        m_rd = ex_rd;
      end else if (m_rem > 0) m_rem--;
    end
  endtask

  task automatic cycle();
    #1 model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_reg_write = 0; id_is_mc = 0;
    ex_valid = 0; ex_rs = '0; ex_rd = '0; ex_mem_read = 0; ex_is_mc = 0; branch_taken_ex = 0;
    mem_rd = '0; mem_reg_write = 0; wb_rd = '0; wb_reg_write = 0; stat_clr = 0;
  endtask

  function automatic logic [RB-1:0] ridx();
    return RB'($urandom_range(0, 4));
  endfunction

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    m_rem = 0; m_rd = '0; m_cnt = 0;
    @(negedge clk);
    rst = 0;
    #1 chk("rst_busy", mc_busy, 0);
    chk("rst_done", mc_done, 0);
    chk("rst_count", stall_count, 0);
    cycle();
    // forwarding priority and x0
    ex_rs = {5'd0, 5'd5}; mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
    #1 chk("fwd_mem", fwd_sel[1:0], 2'b01);
    cycle();
    mem_reg_write = 0;
    #1 chk("fwd_wb", fwd_sel[1:0], 2'b10);
    cycle();
    ex_rs = '0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1;
    #1 chk("fwd_x0", fwd_sel, 4'b0000);
    cycle();
    // load-use
    idle();
    ex_valid = 1; ex_mem_read = 1; ex_rd = 7; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
    #1 chk("lu_stall_if", stall_if, 1);
    chk("lu_stall_id", stall_id, 1);
    chk("lu_bubble", bubble_ex, 1);
    cycle();
    id_rs_used = 2'b00;
    #1 chk("lu_unused", stall_id, 0);
    chk("lu_count", stall_count, 1);
    id_rs_used = 2'b01; ex_rd = 0; id_rs = '0;
    #1 chk("lu_x0", stall_id, 0);
    cycle();
    ex_rd = 7; id_rs = {5'd0, 5'd7}; branch_taken_ex = 1;
    #1 chk("br_flush_if", flush_if, 1);
    chk("br_flush_id", flush_id, 1);
    chk("br_stall", {stall_if, stall_id, bubble_ex}, 3'b000);
    cycle();
    idle();
    #1 chk("br_count", stall_count, 1);
    // multi-cycle op, latency 4
    ex_valid = 1; ex_is_mc = 1; ex_rd = 9;
    cycle();
    idle();
    id_rs_used = 2'b01;
    for (int i = 1; i <= LAT; i++) begin
      id_rs = {5'd0, 5'd10};
      #1 chk("mc_x10", stall_id, 0);
      id_rs = {5'd0, 5'd9};
      #1 chk("mc_busy", mc_busy, 1);
      chk("mc_done", mc_done, i == LAT);
      chk("mc_x9", stall_id, 1);
      cycle();
    end
    #1 chk("mc_release_busy", mc_busy, 0);
    chk("mc_release", stall_id, 0);
    cycle();
    // back-to-back ops
    idle();
    ex_valid = 1; ex_is_mc = 1; ex_rd = 9;
    cycle();
    idle();
    for (int i = 1; i <= LAT; i++) begin
      id_is_mc = (i < LAT);
      if (i == LAT) begin ex_valid = 1; ex_is_mc = 1; ex_rd = 12; end
      #1 chk("b2b_stall", stall_id, i < LAT);
      cycle();
    end
    idle();
    #1 chk("b2b_busy", mc_busy, 1);
    chk("b2b_rd", mc_rd, 12);
    chk("b2b_done", mc_done, 0);
    repeat (LAT + 1) cycle();
    // reset mid-op
    ex_valid = 1; ex_is_mc = 1; ex_rd = 9;
    cycle();
    idle();
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    #1 chk("rst_mc_busy", mc_busy, 0);
    chk("rst_mc_rd", mc_rd, 0);
    for (int i = 0; i < LAT + 2; i++) begin
      #1 chk("rst_no_done", mc_done, 0);
      cycle();
    end
    // stall counter saturation and clear
    ex_valid = 1; ex_mem_read = 1; ex_rd = 7; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
    repeat (CMAX) cycle();
    #1 chk("sat_full", stall_count, CMAX);
    cycle();
    #1 chk("sat_hold", stall_count, CMAX);
    stat_clr = 1;
    cycle();
    idle();
    #1 chk("stat_clr", stall_count, 0);
    cycle();
    // randomized run
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      stat_clr = ($urandom_range(0, 31) == 0);
      id_rs = {ridx(), ridx()};
      id_rs_used = NS'($urandom);
      id_rd = ridx();
      id_reg_write = $urandom_range(0, 1);
      id_is_mc = ($urandom_range(0, 7) == 0);
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_rs = {ridx(), ridx()};
      ex_rd = ridx();
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_is_mc = ($urandom_range(0, 3) == 0);
      branch_taken_ex = ($urandom_range(0, 7) == 0);
      mem_rd = ridx();
      mem_reg_write = $urandom_range(0, 1);
      wb_rd = ridx();
      wb_reg_write = $urandom_range(0, 1);
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
